// File: rtl/calc_disp_pkg.sv
// Shared types and segment constants for the calculator display scanner.
// Segments are active-low, ordered {g,f,e,d,c,b,a}.
package calc_disp_pkg;

  typedef enum logic [0:0] {
    S_GUARD = 1'b0,
    S_ON    = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    GLYPH_NIB   = 2'd0,
    GLYPH_BLANK = 2'd1,
    GLYPH_E     = 2'd2,
    GLYPH_R     = 2'd3
  } glyph_t;

  localparam logic [3:0] BLANK     = 4'hF;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_R     = 7'h2F;

  function automatic logic [6:0] nib2seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      BLANK:   seg = SEG_BLANK;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/calc_display_scan_decode.sv
// Combinational segment decoder: nibble or special glyph (blank, E, r).
module calc_seg_decode
  import calc_disp_pkg::*;
(
  input  logic [3:0] i_nib,
  input  logic [1:0] i_glyph,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_glyph)
      GLYPH_NIB: o_seg = nib2seg(i_nib);
      GLYPH_E:   o_seg = SEG_E;
      GLYPH_R:   o_seg = SEG_R;
      default:   o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/calc_display_scan.sv
// 4-digit multiplexed 7-segment scanner for the calculator with per-frame input snapshot.
// Optional blinking of the error pattern: define CALC_DISP_ERR_BLINK_EN.
module calc_display_scan
  import calc_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned GUARD_CYC    = 500,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ansrdy,
  input  logic [3:0] i_ans0,
  input  logic [3:0] i_ans10,
  input  logic [3:0] i_ans100,
  input  logic [3:0] i_ans1000,
  input  logic [3:0] i_num1_0,
  input  logic [3:0] i_num1_1,
  input  logic [3:0] i_num2_0,
  input  logic [3:0] i_num2_1,
  output logic [3:0] o_an,
  output logic [6:0] o_seg,
  output logic       o_dp,
  output logic       o_frame
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_TC    = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD_CYC);

  if (SCAN_DIV < 4 || SCAN_DIV > (1 << 20) || GUARD_CYC >= SCAN_DIV || BLINK_FRAMES < 1) begin : g_bad_param
    $error("calc_display_scan: illegal parameter set");
  end

  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [1:0]      r_idx;
  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_tc;
  logic            w_snap;
  logic [3:0][3:0] r_ans;
  logic [3:0][3:0] r_num;
  logic            r_rdy;
  logic            w_err;
  logic [3:0]      w_sup;
  logic [3:0]      w_nib;
  logic [1:0]      w_glyph;
  logic            w_dp_on;
  logic [6:0]      w_seg;
  logic            w_hide;

  always_comb begin
    w_tc        = (r_cnt == CNT_TC);
    w_snap      = w_tc && (r_idx == 2'd0);
    w_cnt_nxt   = w_tc ? '0 : r_cnt + CW'(1);
    w_state_nxt = (w_cnt_nxt >= CNT_GUARD) ? S_ON : S_GUARD;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_state <= S_GUARD;
      r_ans   <= {4{BLANK}};
      r_num   <= {4{BLANK}};
      r_rdy   <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_state <= w_state_nxt;
      if (w_tc) r_idx <= r_idx - 2'd1;
      if (w_snap) begin
        r_ans <= {i_ans1000, i_ans100, i_ans10, i_ans0};
        r_num <= {i_num1_1, i_num1_0, i_num2_1, i_num2_0};
        r_rdy <= i_ansrdy;
      end
    end
  end

  // A zero is suppressed only while every more-significant digit is zero or blank
  always_comb begin
    w_err    = r_rdy && (r_ans == {4{BLANK}});
    w_sup[3] = (r_ans[3] == 4'h0);
    w_sup[2] = (r_ans[2] == 4'h0) && (r_ans[3] == 4'h0 || r_ans[3] == BLANK);
    w_sup[1] = (r_ans[1] == 4'h0) && (r_ans[3] == 4'h0 || r_ans[3] == BLANK)
                                  && (r_ans[2] == 4'h0 || r_ans[2] == BLANK);
    w_sup[0] = 1'b0;
  end

  always_comb begin
    w_nib   = r_num[r_idx];
    w_glyph = GLYPH_NIB;
    w_dp_on = (r_idx == 2'd2);
    if (r_rdy) begin
      w_nib   = r_ans[r_idx];
      w_dp_on = 1'b0;
      if (w_err) begin
        w_glyph = (r_idx == 2'd3) ? GLYPH_BLANK : (r_idx == 2'd2) ? GLYPH_E : GLYPH_R;
      end else if (w_sup[r_idx]) begin
        w_glyph = GLYPH_BLANK;
      end
    end
  end

  calc_seg_decode u_dec (
    .i_nib   (w_nib),
    .i_glyph (w_glyph),
    .o_seg   (w_seg)
  );

`ifdef CALC_DISP_ERR_BLINK_EN
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [BW-1:0] r_bcnt;
  logic          r_bon;
  logic          w_err_in;

  assign w_err_in = i_ansrdy && ({i_ans1000, i_ans100, i_ans10, i_ans0} == {4{BLANK}});

  // Phase restarts "on" on the frame the error first appears in the snapshot
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bcnt <= '0;
      r_bon  <= 1'b1;
    end else if (w_snap) begin
      if (w_err_in && !w_err) begin
        r_bcnt <= '0;
        r_bon  <= 1'b1;
      end else if (r_bcnt == BW'(BLINK_FRAMES - 1)) begin
        r_bcnt <= '0;
        r_bon  <= ~r_bon;
      end else begin
        r_bcnt <= r_bcnt + BW'(1);
      end
    end
  end

  assign w_hide = w_err && !r_bon;
`else
  assign w_hide = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_an    <= 4'hF;
      o_seg   <= SEG_BLANK;
      o_dp    <= 1'b1;
      o_frame <= 1'b0;
    end else begin
      o_frame <= w_snap;
      if (r_state == S_ON && !w_hide) begin
        o_an  <= ~(4'b0001 << r_idx);
        o_seg <= w_seg;
        o_dp  <= ~w_dp_on;
      end else begin
        o_an  <= 4'hF;
        o_seg <= SEG_BLANK;
        o_dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_calc_display_scan.sv
// Self-checking bench for calc_display_scan (SCAN_DIV=8, GUARD_CYC=2, BLINK_FRAMES=2).
module tb_calc_display_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       ansrdy;
  logic [3:0] ans0, ans10, ans100, ans1000;
  logic [3:0] n1_0, n1_1, n2_0, n2_1;
  logic [3:0] o_an;
  logic [6:0] o_seg;
  logic       o_dp, o_frame;

  always #5 clk = ~clk;

  calc_display_scan #(
    .SCAN_DIV     (8),
    .GUARD_CYC    (2),
    .BLINK_FRAMES (2)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_ansrdy  (ansrdy),
    .i_ans0    (ans0),
    .i_ans10   (ans10),
    .i_ans100  (ans100),
    .i_ans1000 (ans1000),
    .i_num1_0  (n1_0),
    .i_num1_1  (n1_1),
    .i_num2_0  (n2_0),
    .i_num2_1  (n2_1),
    .o_an      (o_an),
    .o_seg     (o_seg),
    .o_dp      (o_dp),
    .o_frame   (o_frame)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: edges since reset release, snapshot copy, frames since error appeared
  int         k;
  logic [3:0] m_ans [4];
  logic [3:0] m_num [4];
  logic       m_rdy;
  int         m_n;
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (k=%0d): got %h expected %h", tag, k, obs, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] v);
    if (v <= 4'd9) return seg_tab[v];
    if (v == 4'hF) return 7'h7F;
    return 7'h3F;
  endfunction

  task automatic model_reset();
    k = 0;
    m_rdy = 1'b0;
    m_n = 0;
    for (int i = 0; i < 4; i++) begin
      m_ans[i] = 4'hF;
      m_num[i] = 4'hF;
    end
  endtask

  task automatic model_edge(output logic [3:0] e_an, output logic [6:0] e_seg,
                            output logic e_dp, output logic e_fr);
    int   p, s, pos, idx;
    logic err, err_in, hide, blank;
    k++;
    p   = k - 1;
    s   = p / 8;
    pos = p % 8;
    idx = (4 - (s % 4)) % 4;
    e_fr = ((k % 32) == 8);
    err  = m_rdy && m_ans[0] == 4'hF && m_ans[1] == 4'hF && m_ans[2] == 4'hF && m_ans[3] == 4'hF;
    hide = 1'b0;
`ifdef CALC_DISP_ERR_BLINK_EN
    hide = err && (((m_n / 2) % 2) != 0);
`endif
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    if (pos >= 2 && !hide) begin
      e_an[idx] = 1'b0;
      if (!m_rdy) begin
        e_seg = glyph(m_num[idx]);
        e_dp  = (idx != 2);
      end else if (err) begin
        e_seg = (idx == 3) ? 7'h7F : (idx == 2) ? 7'h06 : 7'h2F;
      end else begin
        blank = (m_ans[idx] == 4'h0) && (idx != 0);
        for (int d = idx + 1; d < 4; d++)
          if (m_ans[d] != 4'h0 && m_ans[d] != 4'hF) blank = 1'b0;
        e_seg = blank ? 7'h7F : glyph(m_ans[idx]);
      end
    end
    if (e_fr) begin
      err_in = ansrdy && ans0 == 4'hF && ans10 == 4'hF && ans100 == 4'hF && ans1000 == 4'hF;
      if (err_in && !err) m_n = 0;
      else m_n++;
      m_rdy = ansrdy;
      m_ans[0] = ans0;  m_ans[1] = ans10;  m_ans[2] = ans100; m_ans[3] = ans1000;
      m_num[0] = n2_0;  m_num[1] = n2_1;   m_num[2] = n1_0;   m_num[3] = n1_1;
    end
  endtask

  task automatic cycle();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_fr;
    @(posedge clk);
    model_edge(e_an, e_seg, e_dp, e_fr);
    @(negedge clk);
    chk("o_frame", o_frame, e_fr);
    chk("o_an", o_an, e_an);
    chk("o_seg", o_seg, e_seg);
    chk("o_dp", o_dp, e_dp);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic set_ops(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    ansrdy = 1'b0; n1_1 = a; n1_0 = b; n2_1 = c; n2_0 = d;
  endtask

  task automatic set_ans(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    ansrdy = 1'b1; ans1000 = a; ans100 = b; ans10 = c; ans0 = d;
  endtask

  function automatic logic [3:0] rnd_dig();
    case ($urandom_range(0, 3))
      0:       return 4'h0;
      1:       return 4'hF;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_an"}, o_an, 4'hF);
    chk({tag, "_seg"}, o_seg, 7'h7F);
    chk({tag, "_dp"}, o_dp, 1'b1);
    chk({tag, "_frame"}, o_frame, 1'b0);
  endtask

  initial begin
    int waited;
    rst = 1'b1;
    set_ops(4'hF, 4'hF, 4'hF, 4'hF);
    set_ans(4'hF, 4'hF, 4'hF, 4'hF);
    ansrdy = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("rst_init");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Operands 42 and _7, dp separator on digit 2
    set_ops(4'h4, 4'h2, 4'hF, 4'h7);
    run(64);
    // Answer 0042, then 0000
    set_ans(4'h0, 4'h0, 4'h4, 4'h2);
    run(64);
    set_ans(4'h0, 4'h0, 4'h0, 4'h0);
    run(64);
    // Error pattern held across several frames (blink visible when enabled)
    set_ans(4'hF, 4'hF, 4'hF, 4'hF);
    run(160);
    // Mid-frame change of the units digit
    set_ans(4'h0, 4'h0, 4'h0, 4'h3);
    run(44);
    ans0 = 4'h8;
    run(56);
    // Non-decimal operand digit shows a dash
    set_ops(4'h1, 4'hB, 4'h0, 4'h9);
    run(64);

    // Asynchronous reset while an anode is lit
    waited = 0;
    while (o_an == 4'hF && waited < 16) begin
      cycle();
      waited++;
    end
    chk("anode_lit_before_reset", (o_an != 4'hF), 1'b1);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("rst_hold");
    rst = 1'b0;
    model_reset();
    run(64);

    // Randomised inputs, changed at arbitrary points within frames
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        set_ops(rnd_dig(), rnd_dig(), rnd_dig(), rnd_dig());
      end else if ($urandom_range(0, 5) == 0) begin
        set_ans(4'hF, 4'hF, 4'hF, 4'hF);
      end else begin
        set_ans(rnd_dig(), rnd_dig(), rnd_dig(), rnd_dig());
      end
      run($urandom_range(10, 80));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
